// File: rtl/hazard_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scheduler_pkg
//  Description : Shared encodings for the hazard scheduler. Holds the
//                forwarding-mux select values, the scheduler FSM states
//                and the hardwired-zero register index.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_scheduler_pkg;

  // Forwarding mux select encodings for the EX operand muxes
  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB result

  // Register r0 is hardwired to zero and is never a real dependency
  localparam int unsigned REG_ZERO = 0;

  // Width of the mul/div occupancy counter (covers MD_LATENCY up to 15)
  localparam int unsigned MD_CNT_W = 4;

  // Scheduler FSM
  typedef enum logic {
    ST_RUN     = 1'b0,  // normal issue; branch / mul-div entry / load-use
    ST_MD_BUSY = 1'b1   // multi-cycle mul/div holding EX
  } state_e;

endpackage : hazard_scheduler_pkg
`default_nettype wire

// File: rtl/hazard_scheduler_fwd_select_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select_unit
//  Description : Operand forwarding select for one EX-stage operand.
//                EX/MEM has priority over MEM/WB; r0 is never forwarded.
//  Ports       : addr_i       - source register of the EX operand
//                mem_dest_i   - EX/MEM destination register
//                mem_we_i     - EX/MEM write-back flag
//                wb_dest_i    - MEM/WB destination register
//                wb_we_i      - MEM/WB write-back flag
//                sel_o        - mux select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select_unit
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] mem_dest_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] wb_dest_i,
  input  logic              wb_we_i,
  output logic [1:0]        sel_o
);

  localparam logic [ADDR_W-1:0] c_reg_zero = ADDR_W'(REG_ZERO);

  logic w_addr_nonzero;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_addr_nonzero = (addr_i != c_reg_zero);
  assign w_hit_mem      = mem_we_i && (mem_dest_i == addr_i) && w_addr_nonzero;
  assign w_hit_wb       = wb_we_i  && (wb_dest_i  == addr_i) && w_addr_nonzero;

  always_comb begin
    sel_o = FWD_RF;
    // The younger EX/MEM result shadows an older MEM/WB write to the same reg
    if (w_hit_mem) begin
      sel_o = FWD_EXMEM;
    end else if (w_hit_wb) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule : fwd_select_unit
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scheduler
//  Description : Hazard controller for the 5-stage core. Produces stage
//                enables, flushes and bubbles for taken branches, the
//                multi-cycle mul/div unit and load-use stalls, drives the
//                EX forwarding selects and counts front-end stall cycles.
//  Ports       : clk_i, rst_i            - clock, sync active-high reset
//                id_*_i                  - ID-stage source regs / usage
//                ex_*_i                  - EX-stage sources, dest, flags
//                mem_* / wb_*_i          - downstream dest + write flags
//                pc/if_id/id_ex_write_en_o - pipeline register enables
//                if_id_flush_o, id_ex_bubble_o, ex_mem_bubble_o - NOP inserts
//                fwd_a_sel_o, fwd_b_sel_o - EX operand forwarding selects
//                stall_cycles_o          - saturating PC-stall cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MD_LATENCY  = 4,
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REG_ADDR_W-1:0]  id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0]  id_rt_addr_i,
  input  logic                   id_rs_used_i,
  input  logic                   id_rt_used_i,
  input  logic [REG_ADDR_W-1:0]  ex_rs_addr_i,
  input  logic [REG_ADDR_W-1:0]  ex_rt_addr_i,
  input  logic [REG_ADDR_W-1:0]  ex_dest_addr_i,
  input  logic                   ex_reg_write_i,
  input  logic                   ex_mem_read_i,
  input  logic                   ex_muldiv_i,
  input  logic                   ex_branch_taken_i,
  input  logic [REG_ADDR_W-1:0]  mem_dest_addr_i,
  input  logic                   mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0]  wb_dest_addr_i,
  input  logic                   wb_reg_write_i,
  output logic                   pc_write_en_o,
  output logic                   if_id_write_en_o,
  output logic                   id_ex_write_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_bubble_o,
  output logic                   ex_mem_bubble_o,
  output logic [1:0]             fwd_a_sel_o,
  output logic [1:0]             fwd_b_sel_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  localparam logic [REG_ADDR_W-1:0]  c_reg_zero   = REG_ADDR_W'(REG_ZERO);
  // Entry cycle plus the busy countdown to zero gives MD_LATENCY-1 stall
  // cycles; the release cycle then lets the result move to MEM.
  localparam logic [MD_CNT_W-1:0]    c_md_reload  = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [MD_CNT_W-1:0]    c_md_one     = MD_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] c_cnt_one    = STALL_CNT_W'(1);

  generate
    if ((MD_LATENCY < 2) || (MD_LATENCY > 15)) begin : g_bad_latency
      $error("hazard_scheduler: MD_LATENCY must be within 2..15");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [MD_CNT_W-1:0]     md_cnt_q, md_cnt_d;
  logic [STALL_CNT_W-1:0]  stall_cycles_q;

  logic w_luse;
  logic w_rs_match;
  logic w_rt_match;

  // --------------------------------------------------------------------------
  // Forwarding selects, one unit per EX operand
  // --------------------------------------------------------------------------
  fwd_select_unit #(
    .ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .addr_i     (ex_rs_addr_i),
    .mem_dest_i (mem_dest_addr_i),
    .mem_we_i   (mem_reg_write_i),
    .wb_dest_i  (wb_dest_addr_i),
    .wb_we_i    (wb_reg_write_i),
    .sel_o      (fwd_a_sel_o)
  );

  fwd_select_unit #(
    .ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .addr_i     (ex_rt_addr_i),
    .mem_dest_i (mem_dest_addr_i),
    .mem_we_i   (mem_reg_write_i),
    .wb_dest_i  (wb_dest_addr_i),
    .wb_we_i    (wb_reg_write_i),
    .sel_o      (fwd_b_sel_o)
  );

  // --------------------------------------------------------------------------
  // Load-use detection: a load in EX whose result the ID instruction reads
  // --------------------------------------------------------------------------
  assign w_rs_match = id_rs_used_i && (id_rs_addr_i == ex_dest_addr_i);
  assign w_rt_match = id_rt_used_i && (id_rt_addr_i == ex_dest_addr_i);
  assign w_luse     = ex_mem_read_i && ex_reg_write_i &&
                      (ex_dest_addr_i != c_reg_zero) &&
                      (w_rs_match || w_rt_match);

  // --------------------------------------------------------------------------
  // Next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    md_cnt_d         = md_cnt_q;
    pc_write_en_o    = 1'b1;
    if_id_write_en_o = 1'b1;
    id_ex_write_en_o = 1'b1;
    if_id_flush_o    = 1'b0;
    id_ex_bubble_o   = 1'b0;
    ex_mem_bubble_o  = 1'b0;

    if (rst_i) begin
      // Hold every stage and fill the pipe with NOPs while in reset
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
      id_ex_write_en_o = 1'b0;
      if_id_flush_o    = 1'b1;
      id_ex_bubble_o   = 1'b1;
      ex_mem_bubble_o  = 1'b1;
      state_d          = ST_RUN;
      md_cnt_d         = '0;
    end else if (state_q == ST_RUN) begin
      if (ex_branch_taken_i) begin
        // PC loads the target; the two wrong-path instructions are killed.
        // A load-use match here belongs to a squashed instruction.
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (ex_muldiv_i) begin
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        id_ex_write_en_o = 1'b0;
        ex_mem_bubble_o  = 1'b1;
        state_d          = ST_MD_BUSY;
        md_cnt_d         = c_md_reload;
      end else if (w_luse) begin
        // Hold IF and ID one cycle; the load reaches MEM and forwarding
        // resolves the dependency on the following cycle.
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        id_ex_bubble_o   = 1'b1;
      end
    end else begin
      // ST_MD_BUSY: the unit owns EX, all other hazard sources are ignored
      if (md_cnt_q != '0) begin
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        id_ex_write_en_o = 1'b0;
        ex_mem_bubble_o  = 1'b1;
        md_cnt_d         = md_cnt_q - c_md_one;
      end else begin
        // Release cycle: default outputs let the result advance to MEM
        state_d = ST_RUN;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State, occupancy counter and saturating stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_RUN;
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (!pc_write_en_o && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + c_cnt_one;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule : hazard_scheduler
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scheduler
//  Description : Self-checking bench for hazard_scheduler. Directed
//                scenarios followed by randomized traffic, all compared
//                against a cycle-level behavioural model of the pipeline
//                hazard rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

  localparam int unsigned MD_LATENCY  = 4;
  localparam int unsigned STALL_CNT_W = 6;  // small so saturation is reachable
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int          CNT_MAX     = (1 << STALL_CNT_W) - 1;

  typedef struct packed {
    logic                  rst;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_we;
    logic                  ex_load;
    logic                  ex_md;
    logic                  ex_br;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_we;
  } stim_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [REG_ADDR_W-1:0]  id_rs_addr_i, id_rt_addr_i;
  logic                   id_rs_used_i, id_rt_used_i;
  logic [REG_ADDR_W-1:0]  ex_rs_addr_i, ex_rt_addr_i, ex_dest_addr_i;
  logic                   ex_reg_write_i, ex_mem_read_i, ex_muldiv_i, ex_branch_taken_i;
  logic [REG_ADDR_W-1:0]  mem_dest_addr_i, wb_dest_addr_i;
  logic                   mem_reg_write_i, wb_reg_write_i;
  logic                   pc_write_en_o, if_id_write_en_o, id_ex_write_en_o;
  logic                   if_id_flush_o, id_ex_bubble_o, ex_mem_bubble_o;
  logic [1:0]             fwd_a_sel_o, fwd_b_sel_o;
  logic [STALL_CNT_W-1:0] stall_cycles_o;

  always #5 clk_i = ~clk_i;

  hazard_scheduler #(
    .MD_LATENCY  (MD_LATENCY),
    .STALL_CNT_W (STALL_CNT_W),
    .REG_ADDR_W  (REG_ADDR_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs_addr_i      (id_rs_addr_i),
    .id_rt_addr_i      (id_rt_addr_i),
    .id_rs_used_i      (id_rs_used_i),
    .id_rt_used_i      (id_rt_used_i),
    .ex_rs_addr_i      (ex_rs_addr_i),
    .ex_rt_addr_i      (ex_rt_addr_i),
    .ex_dest_addr_i    (ex_dest_addr_i),
    .ex_reg_write_i    (ex_reg_write_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_muldiv_i       (ex_muldiv_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .mem_dest_addr_i   (mem_dest_addr_i),
    .mem_reg_write_i   (mem_reg_write_i),
    .wb_dest_addr_i    (wb_dest_addr_i),
    .wb_reg_write_i    (wb_reg_write_i),
    .pc_write_en_o     (pc_write_en_o),
    .if_id_write_en_o  (if_id_write_en_o),
    .id_ex_write_en_o  (id_ex_write_en_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .ex_mem_bubble_o   (ex_mem_bubble_o),
    .fwd_a_sel_o       (fwd_a_sel_o),
    .fwd_b_sel_o       (fwd_b_sel_o),
    .stall_cycles_o    (stall_cycles_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: how many more cycles the mul/div keeps EX (0 = none),
  // and the number of cycles the PC has been held since reset.
  int md_left   = 0;
  int model_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_model(input int addr, input stim_t s);
    if (addr != 0 && s.mem_we && int'(s.mem_dest) == addr) return 1;
    if (addr != 0 && s.wb_we  && int'(s.wb_dest)  == addr) return 2;
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // One clock cycle: drive, compare against model, advance model
  task automatic run_cycle(input stim_t s);
    int e_pc, e_ifid, e_idex, e_flush, e_bub, e_exbub;
    bit luse;
    @(negedge clk_i);
    rst_i = s.rst;
    id_rs_addr_i = s.id_rs;       id_rt_addr_i = s.id_rt;
    id_rs_used_i = s.id_rs_used;  id_rt_used_i = s.id_rt_used;
    ex_rs_addr_i = s.ex_rs;       ex_rt_addr_i = s.ex_rt;
    ex_dest_addr_i = s.ex_dest;   ex_reg_write_i = s.ex_we;
    ex_mem_read_i = s.ex_load;    ex_muldiv_i = s.ex_md;
    ex_branch_taken_i = s.ex_br;
    mem_dest_addr_i = s.mem_dest; mem_reg_write_i = s.mem_we;
    wb_dest_addr_i = s.wb_dest;   wb_reg_write_i = s.wb_we;
    #1;
    luse = s.ex_load && s.ex_we && s.ex_dest != 0 &&
           ((s.id_rs_used && s.id_rs == s.ex_dest) ||
            (s.id_rt_used && s.id_rt == s.ex_dest));
    e_pc = 1; e_ifid = 1; e_idex = 1; e_flush = 0; e_bub = 0; e_exbub = 0;
    if (s.rst) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_flush = 1; e_bub = 1; e_exbub = 1;
    end else if (md_left > 1) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exbub = 1;
    end else if (md_left == 1) begin
      // release cycle: nothing held
    end else if (s.ex_br) begin
      e_flush = 1; e_bub = 1;
    end else if (s.ex_md) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exbub = 1;
    end else if (luse) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end
    check("pc_we",    int'(pc_write_en_o),    e_pc);
    check("ifid_we",  int'(if_id_write_en_o), e_ifid);
    check("idex_we",  int'(id_ex_write_en_o), e_idex);
    check("ifid_fl",  int'(if_id_flush_o),    e_flush);
    check("idex_bub", int'(id_ex_bubble_o),   e_bub);
    check("exmem_bub",int'(ex_mem_bubble_o),  e_exbub);
    check("fwd_a",    int'(fwd_a_sel_o),      fwd_model(int'(s.ex_rs), s));
    check("fwd_b",    int'(fwd_b_sel_o),      fwd_model(int'(s.ex_rt), s));
    check("stall_cnt",int'(stall_cycles_o),   model_cnt);
    // advance model to the state after the coming clock edge
    if (s.rst) begin
      md_left = 0; model_cnt = 0;
    end else begin
      if (e_pc == 0 && model_cnt < CNT_MAX) model_cnt++;
      if (md_left > 0)               md_left--;
      else if (!s.ex_br && s.ex_md)  md_left = MD_LATENCY - 1;
    end
  endtask

  task automatic rand_stim(output stim_t s, input int md_pct, input int rst_pct);
    s.rst        = ($urandom_range(0, 99) < rst_pct);
    s.id_rs      = REG_ADDR_W'($urandom_range(0, 3));
    s.id_rt      = REG_ADDR_W'($urandom_range(0, 3));
    s.id_rs_used = 1'($urandom_range(0, 1));
    s.id_rt_used = 1'($urandom_range(0, 1));
    s.ex_rs      = REG_ADDR_W'($urandom_range(0, 3));
    s.ex_rt      = REG_ADDR_W'($urandom_range(0, 3));
    s.ex_dest    = REG_ADDR_W'($urandom_range(0, 3));
    s.ex_we      = ($urandom_range(0, 99) < 80);
    s.ex_load    = ($urandom_range(0, 99) < 35);
    s.ex_md      = ($urandom_range(0, 99) < md_pct);
    s.ex_br      = ($urandom_range(0, 99) < 10);
    s.mem_dest   = REG_ADDR_W'($urandom_range(0, 3));
    s.mem_we     = 1'($urandom_range(0, 1));
    s.wb_dest    = REG_ADDR_W'($urandom_range(0, 3));
    s.wb_we      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    stim_t s;
    int    base;

    // Bring the DUT to a known state before any comparison
    rst_i = 1'b1;
    {id_rs_addr_i, id_rt_addr_i, id_rs_used_i, id_rt_used_i} = '0;
    {ex_rs_addr_i, ex_rt_addr_i, ex_dest_addr_i} = '0;
    {ex_reg_write_i, ex_mem_read_i, ex_muldiv_i, ex_branch_taken_i} = '0;
    {mem_dest_addr_i, mem_reg_write_i, wb_dest_addr_i, wb_reg_write_i} = '0;
    @(posedge clk_i);
    s = idle(); s.rst = 1'b1;
    run_cycle(s);
    run_cycle(idle());
    check("reset_cnt", int'(stall_cycles_o), 0);

    // Load-use on rs, then the consumer sees the load result via MEM/WB
    s = idle(); s.ex_load = 1; s.ex_we = 1; s.ex_dest = 3;
    s.id_rs = 3; s.id_rs_used = 1;
    run_cycle(s);
    s = idle(); s.ex_rs = 3; s.wb_dest = 3; s.wb_we = 1;
    run_cycle(s);
    check("luse_cnt", int'(stall_cycles_o), 1);

    // Load to r0 never stalls
    s = idle(); s.ex_load = 1; s.ex_we = 1; s.ex_dest = 0;
    s.id_rs = 0; s.id_rs_used = 1; s.mem_we = 1; s.wb_we = 1;
    run_cycle(s);

    // Single mul/div, then back-to-back pair
    base = int'(stall_cycles_o);
    s = idle(); s.ex_md = 1;
    for (int i = 0; i < MD_LATENCY; i++) run_cycle(s);
    run_cycle(idle());
    check("md1_stalls", int'(stall_cycles_o) - base, MD_LATENCY - 1);
    base = int'(stall_cycles_o);
    for (int i = 0; i < 2 * MD_LATENCY; i++) run_cycle(s);
    run_cycle(idle());
    check("md2_stalls", int'(stall_cycles_o) - base, 2 * (MD_LATENCY - 1));

    // Branch wins over a simultaneous load-use match
    s = idle(); s.ex_br = 1; s.ex_load = 1; s.ex_we = 1; s.ex_dest = 2;
    s.id_rt = 2; s.id_rt_used = 1;
    run_cycle(s);

    // Forwarding priority on operand A, and on operand B with MEM/WB only
    s = idle(); s.ex_rs = 5; s.ex_rt = 5;
    s.mem_dest = 5; s.mem_we = 1; s.wb_dest = 5; s.wb_we = 1;
    run_cycle(s);
    s.mem_we = 0;
    run_cycle(s);

    // Reset during the second MD_BUSY cycle, then an ALU op
    s = idle(); s.ex_md = 1;
    run_cycle(s);
    run_cycle(s);
    s.rst = 1;
    run_cycle(s);
    s = idle(); s.ex_rs = 1; s.ex_rt = 2;
    run_cycle(s);
    check("post_rst_cnt", int'(stall_cycles_o), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rand_stim(s, 10, 3);
      run_cycle(s);
    end

    // Heavy mul/div traffic without reset drives the counter to saturation
    for (int i = 0; i < 300; i++) begin
      rand_stim(s, 50, 0);
      run_cycle(s);
    end
    check("sat_cnt", int'(stall_cycles_o), CNT_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_scheduler
`default_nettype wire
